// File: rtl/accel_thread_arbiter_pkg.sv
// Shared definitions for the flow-table accelerator thread arbiter.
//   arb_state_e     : top-level sequencing states (lookup / drain / table write / settle)
//   inflight_width  : width of the outstanding-lookup counter for a given accelerator latency
package accel_thread_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_CFG_WR = 2'd2,
      ST_SETTLE = 2'd3
   } arb_state_e;

   // A fully pipelined accelerator can hold at most ACC_LAT lookups; the
   // extra headroom keeps the counter from wrapping on a transient overlap.
   function automatic int inflight_width(input int acc_lat);
      return $clog2(acc_lat + 2);
   endfunction

endpackage

// File: rtl/accel_thread_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req : request vector (one bit per requester)
//   ptr : index with highest priority this cycle
//   gnt : one-hot grant of the first requester at or after ptr (wrapping)
//   idx : encoded index of the granted requester
//   any : at least one requester was granted
module accel_thread_arbiter_rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      int j;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr) + i) % N;
         if (!any && req[j]) begin
            gnt[j] = 1'b1;
            idx    = IDX_W'(j);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/accel_thread_arbiter.sv
// Shares one source-IP flow-table accelerator among NUM_THREADS threads.
//   req/req_ip/req_eop      : per-thread lookup requests (level) with IP and end-of-packet flag
//   gnt                     : one-hot grant, same cycle as acc_start
//   resp_valid/action/match : response steered back to the thread named by acc_thread_id_out
//   cfg_req/cfg_*/cfg_ack   : table write, issued after in-flight lookups drain, then a settle window
//   cnt_rd_*                : counter read forwarded to the accelerator, valid CNT_RD_LAT later
//   acc_*                   : accelerator interface
module accel_thread_arbiter
   import accel_thread_arbiter_pkg::*;
#(
   parameter int FT_ADDR_WIDTH = 4,
   parameter int NUM_ACTIONS   = 4,
   parameter int NUM_THREADS   = 4,
   parameter int THREAD_BITS   = 2,
   parameter int ACC_LAT       = 2,
   parameter int MATCH_LAT     = 1,
   parameter int CFG_SETTLE    = 16,
   parameter int CNT_RD_LAT    = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_THREADS-1:0]      req,
   input  logic [NUM_THREADS*32-1:0]   req_ip,
   input  logic [NUM_THREADS-1:0]      req_eop,
   output logic [NUM_THREADS-1:0]      gnt,
   output logic [NUM_THREADS-1:0]      resp_valid,
   output logic [NUM_ACTIONS-1:0]      resp_action,
   output logic                        resp_match,
   input  logic                        cfg_req,
   input  logic [31:0]                 cfg_ip,
   input  logic [NUM_ACTIONS-1:0]      cfg_action,
   input  logic [FT_ADDR_WIDTH-1:0]    cfg_addr,
   output logic                        cfg_ack,
   input  logic                        cnt_rd_req,
   input  logic [FT_ADDR_WIDTH-1:0]    cnt_rd_addr,
   output logic                        cnt_rd_valid,
   output logic [31:0]                 cnt_rd_data,
   output logic [31:0]                 acc_ip,
   output logic [THREAD_BITS-1:0]      acc_thread_id,
   output logic                        acc_start,
   output logic                        acc_end_of_pkt,
   output logic [31:0]                 acc_ft_ip,
   output logic [NUM_ACTIONS-1:0]      acc_ft_action,
   output logic [FT_ADDR_WIDTH-1:0]    acc_ft_addr,
   output logic                        acc_setup_ft,
   output logic                        acc_read_counter,
   output logic [FT_ADDR_WIDTH-1:0]    acc_counter_rd_addr,
   input  logic [NUM_ACTIONS-1:0]      acc_action,
   input  logic                        acc_match,
   input  logic                        acc_done,
   input  logic [NUM_THREADS-1:0]      acc_thread_id_out,
   input  logic [31:0]                 acc_count
);

   localparam int IW = inflight_width(ACC_LAT);
   localparam int SW = $clog2(CFG_SETTLE + 1);

   arb_state_e               state_q, state_d;
   logic [THREAD_BITS-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NUM_THREADS-1:0]   busy_q, busy_d;
   logic [IW-1:0]            inflight_q, inflight_d;
   logic [SW-1:0]            settle_cnt_q, settle_cnt_d;
   logic [MATCH_LAT-1:0]     eop_pipe_q, eop_pipe_d;
   logic [CNT_RD_LAT-1:0]    cnt_pipe_q, cnt_pipe_d;

   logic [NUM_THREADS-1:0]   eligible;
   logic [NUM_THREADS-1:0]   arb_gnt;
   logic [THREAD_BITS-1:0]   arb_idx;
   logic                     arb_any;
   logic                     grant;
   logic [THREAD_BITS-1:0]   done_tid;
   logic                     done_ok;
   logic                     settle_done;
   logic                     cfg_wr;
   logic                     unused_tid_hi;

   // busy_q (not busy_d) gates eligibility, so a thread answered this cycle
   // can only be granted again from the next cycle on.
   assign eligible = req & ~busy_q;

   accel_thread_arbiter_rr_arbiter #(
      .N     (NUM_THREADS),
      .IDX_W (THREAD_BITS)
   ) u_rr (
      .req (eligible),
      .ptr (rr_ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   assign done_tid      = acc_thread_id_out[THREAD_BITS-1:0];
   assign unused_tid_hi = ^acc_thread_id_out;
   // A completion for a thread with nothing outstanding is dropped.
   assign done_ok       = !reset && acc_done && busy_q[done_tid];
   assign grant         = !reset && (state_q == ST_RUN) && !cfg_req && arb_any;
   assign settle_done   = (settle_cnt_q == SW'(CFG_SETTLE - 1));
   assign cfg_wr        = !reset && (state_q == ST_CFG_WR);

   // End-of-packet flag rides a MATCH_LAT-deep pipe from grant to the match stage;
   // counter-read requests ride a CNT_RD_LAT-deep pipe to their data-valid.
   assign eop_pipe_d[0] = grant && req_eop[arb_idx];
   assign cnt_pipe_d[0] = cnt_rd_req;
   for (genvar gi = 1; gi < MATCH_LAT; gi++) begin : g_eop_pipe
      assign eop_pipe_d[gi] = eop_pipe_q[gi-1];
   end
   for (genvar gi = 1; gi < CNT_RD_LAT; gi++) begin : g_cnt_pipe
      assign cnt_pipe_d[gi] = cnt_pipe_q[gi-1];
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (cfg_req) begin
               state_d = (inflight_q != '0) ? ST_DRAIN : ST_CFG_WR;
            end
         end
         ST_DRAIN: begin
            if (inflight_q == '0) begin
               state_d = ST_CFG_WR;
            end
         end
         ST_CFG_WR: state_d = ST_SETTLE;
         ST_SETTLE: begin
            if (settle_done) begin
               state_d = cfg_req ? ST_CFG_WR : ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Datapath next values
   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      busy_d       = busy_q;
      inflight_d   = inflight_q;
      settle_cnt_d = (state_q == ST_SETTLE) ? settle_cnt_q + 1'b1 : '0;
      if (grant) begin
         busy_d[arb_idx] = 1'b1;
         rr_ptr_d = (arb_idx == THREAD_BITS'(NUM_THREADS - 1)) ? '0 : arb_idx + 1'b1;
      end
      if (done_ok) begin
         busy_d[done_tid] = 1'b0;
      end
      if (grant && !done_ok) begin
         inflight_d = inflight_q + 1'b1;
      end else if (!grant && done_ok) begin
         inflight_d = inflight_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q     <= '0;
         busy_q       <= '0;
         inflight_q   <= '0;
         settle_cnt_q <= '0;
         eop_pipe_q   <= '0;
         cnt_pipe_q   <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         busy_q       <= busy_d;
         inflight_q   <= inflight_d;
         settle_cnt_q <= settle_cnt_d;
         eop_pipe_q   <= eop_pipe_d;
         cnt_pipe_q   <= cnt_pipe_d;
      end
   end

   // Output logic; everything is forced low while reset is asserted.
   always_comb begin
      gnt                 = grant ? arb_gnt : '0;
      acc_start           = grant;
      acc_ip              = '0;
      acc_thread_id       = '0;
      if (grant) begin
         acc_ip        = req_ip[32*arb_idx +: 32];
         acc_thread_id = arb_idx;
      end
      acc_setup_ft        = cfg_wr;
      cfg_ack             = cfg_wr;
      acc_ft_ip           = cfg_wr ? cfg_ip : '0;
      acc_ft_action       = cfg_wr ? cfg_action : '0;
      acc_ft_addr         = cfg_wr ? cfg_addr : '0;
      resp_valid          = '0;
      if (done_ok) begin
         resp_valid[done_tid] = 1'b1;
      end
      resp_action         = done_ok ? acc_action : '0;
      resp_match          = done_ok && acc_match;
      acc_end_of_pkt      = !reset && eop_pipe_q[MATCH_LAT-1];
      acc_read_counter    = !reset && cnt_rd_req;
      acc_counter_rd_addr = reset ? '0 : cnt_rd_addr;
      cnt_rd_valid        = !reset && cnt_pipe_q[CNT_RD_LAT-1];
      cnt_rd_data         = cnt_rd_valid ? acc_count : '0;
   end

   // A completion must always match an outstanding lookup.
   always_ff @(posedge clk) begin
      if (!reset && acc_done) begin
         assert (busy_q[done_tid]);
      end
   end

endmodule

// File: tb/tb_accel_thread_arbiter.sv
// Directed bench for accel_thread_arbiter with a behavioural accelerator
// (ACC_LAT=2 lookup pipe, flow table, counter read with 1-cycle latency) and a
// response scoreboard: expected responses are queued at grant time and popped
// when resp_valid strobes.
module tb_accel_thread_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   req, req_eop, gnt, resp_valid, resp_action;
   logic [127:0] req_ip;
   logic         resp_match, cfg_req, cfg_ack, cnt_rd_req, cnt_rd_valid;
   logic [31:0]  cfg_ip, cnt_rd_data, acc_ip, acc_ft_ip, acc_count;
   logic [3:0]   cfg_action, cfg_addr, cnt_rd_addr, acc_ft_action, acc_ft_addr;
   logic [1:0]   acc_thread_id;
   logic         acc_start, acc_end_of_pkt, acc_setup_ft, acc_read_counter;
   logic [3:0]   acc_counter_rd_addr, acc_action, acc_thread_id_out;
   logic         acc_match, acc_done;

   accel_thread_arbiter dut (
      .clk(clk), .reset(reset), .req(req), .req_ip(req_ip), .req_eop(req_eop),
      .gnt(gnt), .resp_valid(resp_valid), .resp_action(resp_action), .resp_match(resp_match),
      .cfg_req(cfg_req), .cfg_ip(cfg_ip), .cfg_action(cfg_action), .cfg_addr(cfg_addr),
      .cfg_ack(cfg_ack), .cnt_rd_req(cnt_rd_req), .cnt_rd_addr(cnt_rd_addr),
      .cnt_rd_valid(cnt_rd_valid), .cnt_rd_data(cnt_rd_data), .acc_ip(acc_ip),
      .acc_thread_id(acc_thread_id), .acc_start(acc_start), .acc_end_of_pkt(acc_end_of_pkt),
      .acc_ft_ip(acc_ft_ip), .acc_ft_action(acc_ft_action), .acc_ft_addr(acc_ft_addr),
      .acc_setup_ft(acc_setup_ft), .acc_read_counter(acc_read_counter),
      .acc_counter_rd_addr(acc_counter_rd_addr), .acc_action(acc_action),
      .acc_match(acc_match), .acc_done(acc_done), .acc_thread_id_out(acc_thread_id_out),
      .acc_count(acc_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- accelerator model ----------------
   logic [31:0] m_ip  [16];
   logic [3:0]  m_act [16];
   logic        m_v   [16];
   logic        s1_v, s1_m;
   logic [1:0]  s1_tid;
   logic [3:0]  s1_act;

   function automatic logic [4:0] lookup(input logic [31:0] ip);
      logic [4:0] r;
      r = 5'd0;
      for (int i = 0; i < 16; i++) begin
         if (m_v[i] && m_ip[i] == ip) r = {1'b1, m_act[i]};
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) m_v[i] <= 1'b0;
         s1_v <= 1'b0; s1_m <= 1'b0; s1_tid <= 2'd0; s1_act <= 4'd0;
         acc_done <= 1'b0; acc_thread_id_out <= 4'd0; acc_action <= 4'd0; acc_match <= 1'b0;
      end else begin
         if (acc_setup_ft) begin
            m_ip[acc_ft_addr]  <= acc_ft_ip;
            m_act[acc_ft_addr] <= acc_ft_action;
            m_v[acc_ft_addr]   <= 1'b1;
         end
         s1_v   <= acc_start;
         s1_tid <= acc_thread_id;
         {s1_m, s1_act} <= lookup(acc_ip);
         acc_done          <= s1_v;
         acc_thread_id_out <= {2'b00, s1_tid};
         acc_match         <= s1_m;
         acc_action        <= s1_act;
      end
      if (acc_read_counter) acc_count <= 32'hC0DE_0000 | 32'(acc_counter_rd_addr);
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_err = 0;
   int last_resp_cyc = 0;

   typedef struct {
      int         thr;
      logic [3:0] act;
      logic       m;
      int         due;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int thr, input logic [3:0] act, input logic m);
      exp_t e;
      e.thr = thr; e.act = act; e.m = m; e.due = cyc + 2;
      sb.push_back(e);
   endtask

   always begin : mon
      exp_t e;
      @(negedge clk);
      #2;
      if (!reset && resp_valid != 4'd0) begin
         if (sb.size() == 0) begin
            chk("resp_unexpected", 64'(resp_valid), 64'd0);
         end else begin
            e = sb.pop_front();
            chk("resp_onehot", 64'(resp_valid), 64'(4'b0001 << e.thr));
            chk("resp_action", 64'(resp_action), 64'(e.act));
            chk("resp_match", 64'(resp_match), 64'(e.m));
            chk("resp_cycle", 64'(cyc), 64'(e.due));
         end
         last_resp_cyc = cyc;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed %0d cycles without finishing, required completion", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   logic [31:0] ip_tbl [4];
   int          exp1   [5];
   bit          seen;

   initial begin
      ip_tbl = '{32'h0B00_0000, 32'h0A00_0001, 32'hC0A8_0002, 32'h0B00_0003};
      exp1   = '{0, 1, 2, 3, 0};
      reset = 1'b1; req = 4'd0; req_eop = 4'd0; cfg_req = 1'b0; cfg_ip = 32'd0;
      cfg_action = 4'd0; cfg_addr = 4'd0; cnt_rd_req = 1'b0; cnt_rd_addr = 4'd0;
      req_ip = {ip_tbl[3], ip_tbl[2], ip_tbl[1], ip_tbl[0]};

      // Reset: outputs low even with requests present
      repeat (2) @(negedge clk);
      req = 4'hF; cnt_rd_req = 1'b1;
      #1;
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_start", 64'(acc_start), 64'd0);
      chk("rst_rdcnt", 64'(acc_read_counter), 64'd0);
      chk("rst_setup", 64'(acc_setup_ft), 64'd0);
      chk("rst_ack", 64'(cfg_ack), 64'd0);
      chk("rst_cntv", 64'(cnt_rd_valid), 64'd0);
      chk("rst_eop", 64'(acc_end_of_pkt), 64'd0);

      // All four threads requesting: round-robin order 0,1,2,3,0
      @(negedge clk);
      reset = 1'b0; cnt_rd_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         chk("rr_gnt", 64'(gnt), 64'(4'b0001 << exp1[i]));
         chk("rr_tid", 64'(acc_thread_id), 64'(exp1[i]));
         chk("rr_ip", 64'(acc_ip), 64'(ip_tbl[exp1[i]]));
         push(exp1[i], 4'd0, 1'b0);
      end
      @(negedge clk); req = 4'd0; #1;
      chk("rr_idle", 64'(gnt), 64'd0);
      repeat (3) @(negedge clk);

      // Single requester holding req: grant every third cycle, never two outstanding
      req = 4'b0100;
      for (int k = 0; k < 9; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         if (k % 3 == 0) begin
            chk("solo_gnt", 64'(gnt), 64'h4);
            push(2, 4'd0, 1'b0);
         end else begin
            chk("solo_nognt", 64'(gnt), 64'd0);
         end
      end
      @(negedge clk); req = 4'd0;
      repeat (2) @(negedge clk);

      // Table write of 0x0A000001 at addr 3, then thread 1 lookup after settle;
      // a counter read is issued during the settle window.
      cfg_req = 1'b1; cfg_ip = 32'h0A00_0001; cfg_addr = 4'd3; cfg_action = 4'b0101;
      #1;
      chk("cfg_noack_yet", 64'(cfg_ack), 64'd0);
      @(negedge clk); #1;
      chk("cfg_ack", 64'(cfg_ack), 64'd1);
      chk("cfg_setup", 64'(acc_setup_ft), 64'd1);
      chk("cfg_ft_ip", 64'(acc_ft_ip), 64'h0A00_0001);
      chk("cfg_ft_addr", 64'(acc_ft_addr), 64'd3);
      chk("cfg_ft_act", 64'(acc_ft_action), 64'h5);
      cfg_req = 1'b0; req = 4'b0010;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         cnt_rd_req  = (k == 2);
         cnt_rd_addr = (k == 2) ? 4'd5 : 4'd0;
         #1;
         if (k == 2) begin
            chk("rd_fwd", 64'(acc_read_counter), 64'd1);
            chk("rd_addr", 64'(acc_counter_rd_addr), 64'd5);
         end
         if (k == 3) begin
            chk("rd_valid", 64'(cnt_rd_valid), 64'd1);
            chk("rd_data", 64'(cnt_rd_data), 64'hC0DE_0005);
         end
         if (k == 4) chk("rd_valid_end", 64'(cnt_rd_valid), 64'd0);
         if (k <= 16) begin
            chk("settle_nognt", 64'(gnt), 64'd0);
         end else begin
            chk("post_settle_gnt", 64'(gnt), 64'h2);
            chk("post_settle_ip", 64'(acc_ip), 64'h0A00_0001);
            push(1, 4'b0101, 1'b1);
         end
      end
      @(negedge clk); req = 4'd0;
      repeat (3) @(negedge clk);

      // Two lookups in flight when a table write arrives: drain first
      req = 4'b1001; #1;
      chk("drain_gnt3", 64'(gnt), 64'h8);
      push(3, 4'd0, 1'b0);
      @(negedge clk); #1;
      chk("drain_gnt0", 64'(gnt), 64'h1);
      push(0, 4'd0, 1'b0);
      @(negedge clk);
      req = 4'b1000; req_eop = 4'b1000;
      cfg_req = 1'b1; cfg_ip = 32'h0B00_0003; cfg_addr = 4'd7; cfg_action = 4'b1010;
      #1;
      chk("drain_cfg_nognt", 64'(gnt), 64'd0);
      seen = 1'b0;
      for (int w = 0; w < 12 && !seen; w++) begin
         @(negedge clk); #1;
         chk("drain_nognt", 64'(gnt), 64'd0);
         if (cfg_ack) seen = 1'b1;
         else chk("drain_early_setup", 64'(acc_setup_ft), 64'd0);
      end
      chk("drain_ack_seen", 64'(seen), 64'd1);
      chk("drain_setup_cycle", 64'(cyc), 64'(last_resp_cyc + 2));
      chk("drain_empty", 64'(sb.size()), 64'd0);
      chk("drain_setup", 64'(acc_setup_ft), 64'd1);
      chk("drain_ft_ip", 64'(acc_ft_ip), 64'h0B00_0003);
      chk("drain_ft_addr", 64'(acc_ft_addr), 64'd7);
      chk("drain_ft_act", 64'(acc_ft_action), 64'hA);
      cfg_req = 1'b0;

      // Settle window, then thread 3 lookups with and without end-of-packet
      for (int k = 1; k <= 22; k++) begin
         @(negedge clk); #1;
         if (k <= 16) begin
            chk("settle2_nognt", 64'(gnt), 64'd0);
         end else if (k == 17) begin
            chk("eop_gnt", 64'(gnt), 64'h8);
            chk("eop_low_at_start", 64'(acc_end_of_pkt), 64'd0);
            push(3, 4'b1010, 1'b1);
         end else if (k == 18) begin
            chk("eop_high", 64'(acc_end_of_pkt), 64'd1);
            chk("eop_busy_nognt", 64'(gnt), 64'd0);
            req_eop = 4'd0;
         end else if (k == 19) begin
            chk("eop_one_cycle", 64'(acc_end_of_pkt), 64'd0);
            chk("resp_cycle_nognt", 64'(gnt), 64'd0);
         end else if (k == 20) begin
            chk("noeop_gnt", 64'(gnt), 64'h8);
            push(3, 4'b1010, 1'b1);
         end else if (k == 21) begin
            chk("noeop_low", 64'(acc_end_of_pkt), 64'd0);
            req = 4'd0;
         end else begin
            chk("noeop_idle", 64'(gnt), 64'd0);
         end
      end
      repeat (2) @(negedge clk);

      // Reset asserted mid-drain
      req = 4'b0001; #1;
      chk("rd7_gnt", 64'(gnt), 64'h1);
      @(negedge clk);
      req = 4'd0; cfg_req = 1'b1; #1;
      chk("rd7_cfg_nognt", 64'(gnt), 64'd0);
      @(negedge clk);
      reset = 1'b1; req = 4'b0100; cnt_rd_req = 1'b1; #1;
      chk("midrst_gnt", 64'(gnt), 64'd0);
      chk("midrst_resp", 64'(resp_valid), 64'd0);
      chk("midrst_start", 64'(acc_start), 64'd0);
      chk("midrst_ack", 64'(cfg_ack), 64'd0);
      chk("midrst_setup", 64'(acc_setup_ft), 64'd0);
      chk("midrst_rdcnt", 64'(acc_read_counter), 64'd0);
      @(negedge clk);
      reset = 1'b0; cfg_req = 1'b0; cnt_rd_req = 1'b0; #1;
      chk("postrst_run_gnt", 64'(gnt), 64'h4);
      chk("postrst_cntv", 64'(cnt_rd_valid), 64'd0);
      chk("postrst_setup", 64'(acc_setup_ft), 64'd0);
      push(2, 4'd0, 1'b0);
      @(negedge clk);
      req = 4'd0; #1;
      chk("postrst_ack", 64'(cfg_ack), 64'd0);
      chk("postrst_setup2", 64'(acc_setup_ft), 64'd0);
      repeat (4) @(negedge clk);
      #3;
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/accel_thread_arbiter.md
Name: accel_thread_arbiter

Overview:
- Shares one source-IP flow-table accelerator among NUM_THREADS packet-processing threads.
- Round-robin arbitration of lookup requests; each returned action/match is steered back to its requesting thread.
- Sequences flow-table configuration writes: drain in-flight lookups, write, hold a settle window.
- Forwards counter-read requests and times their data-valid.

Parameters:
- FT_ADDR_WIDTH, 4, flow-table address width
- NUM_ACTIONS, 4, action vector width
- NUM_THREADS, 4, number of requesting threads
- THREAD_BITS, 2, log2(NUM_THREADS)
- ACC_LAT, 2, cycles from acc_start to acc_done
- MATCH_LAT, 1, cycles from acc_start to match/counter-update stage
- CFG_SETTLE, 16, lookup-blocked cycles after a table write
- CNT_RD_LAT, 1, cycles from acc_read_counter to valid acc_count

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req  in  NUM_THREADS  per-thread lookup request, level
- req_ip  in  NUM_THREADS*32  per-thread source IP; slice t belongs to thread t
- req_eop  in  NUM_THREADS  per-thread end-of-packet flag, qualifies the counter update
- gnt  out  NUM_THREADS  one-hot one-cycle grant
- resp_valid  out  NUM_THREADS  one-hot one-cycle response strobe
- resp_action  out  NUM_ACTIONS  action for the strobed thread
- resp_match  out  1  match flag for the strobed thread
- cfg_req  in  1  table-write request, level
- cfg_ip  in  32  entry IP
- cfg_action  in  NUM_ACTIONS  entry action
- cfg_addr  in  FT_ADDR_WIDTH  entry address
- cfg_ack  out  1  one-cycle pulse when the write is issued
- cnt_rd_req  in  1  counter read request, pulse
- cnt_rd_addr  in  FT_ADDR_WIDTH  counter index
- cnt_rd_valid  out  1  count data valid
- cnt_rd_data  out  32  count value
- acc_ip  out  32  to accelerator ip_in
- acc_thread_id  out  THREAD_BITS  to accelerator thread_id_in
- acc_start  out  1  to accelerator start_in
- acc_end_of_pkt  out  1  to accelerator end_of_pkt
- acc_ft_ip, acc_ft_action, acc_ft_addr, acc_setup_ft  out  32/NUM_ACTIONS/FT_ADDR_WIDTH/1  table-write port
- acc_read_counter  out  1; acc_counter_rd_addr  out  FT_ADDR_WIDTH
- acc_action  in  NUM_ACTIONS; acc_match  in  1; acc_done  in  1; acc_thread_id_out  in  NUM_THREADS (low THREAD_BITS used); acc_count  in  32

Behaviour:
- Reset: state=RUN, rr pointer=0, busy bits=0, inflight=0; every output is 0.
- FSM states: RUN, DRAIN, CFG_WR, SETTLE.
- RUN, no cfg_req:
  - Eligible threads are those with req[t] high and busy[t]=0.
  - Pick the first eligible thread at or after rr_ptr, wrapping modulo NUM_THREADS.
  - Same cycle: gnt[t]=1, acc_start=1, acc_ip=req_ip[t], acc_thread_id=t; set busy[t]; rr_ptr <= t+1 (wraps).
  - At most one grant per cycle.
- RUN with cfg_req: no new grant. Go to DRAIN if inflight!=0, else to CFG_WR.
- DRAIN: no grants; go to CFG_WR when inflight==0.
- CFG_WR (one cycle):
  - acc_setup_ft=1, acc_ft_* = cfg_*, cfg_ack=1.
  - acc_ip is don't-care and acc_start=0. Then go to SETTLE.
- SETTLE:
  - Count CFG_SETTLE cycles; no grants.
  - A new cfg_req at expiry goes directly to CFG_WR; otherwise return to RUN.
- inflight counter (width clog2(ACC_LAT+2)):
  - +1 on acc_start, -1 on acc_done.
  - Both in the same cycle: no change.
- Responses:
  - On acc_done with t=acc_thread_id_out[THREAD_BITS-1:0]: resp_valid[t]=1 combinationally.
  - resp_action=acc_action, resp_match=acc_match; clear busy[t].
  - acc_done with busy[t]=0 is a protocol error: ignore, and fire a simulation assertion.
- Grant vs response in the same cycle:
  - A thread whose response arrives in cycle N is eligible again from cycle N+1, not N.
  - Requesters must drop req the cycle after gnt, or hold it to request again.
- End of packet:
  - req_eop[t] is captured at grant and shifted through a MATCH_LAT-deep pipe.
  - acc_end_of_pkt is asserted exactly MATCH_LAT cycles after the matching acc_start; 0 otherwise.
- Counter reads are independent of the FSM and allowed in any state:
  - acc_read_counter=cnt_rd_req; acc_counter_rd_addr=cnt_rd_addr.
  - cnt_rd_valid follows CNT_RD_LAT cycles later, with cnt_rd_data=acc_count.
  - Back-to-back reads pipeline.
- Reset mid-operation: returns to RUN, all busy bits clear, all delay pipes clear. Late acc_done from before reset is ignored (accelerator is reset in the same cycle).

Decomposition:
- Shared package: FSM state enum (RUN, DRAIN, CFG_WR, SETTLE) and the inflight width function.
- Natural sub-module: rr_arbiter.
  - Inputs: request vector, pointer. Outputs: one-hot grant, encoded index, any.
  - Purely combinational, reusable elsewhere in the design.

Test Plan:
- Reset, then req=4'b1111 held with busy auto-clearing -> grants in order thread 0,1,2,3,0; each resp_valid arrives 2 cycles after its gnt.
- Only thread 2 requests, re-asserting after each response -> one grant per response, never two outstanding.
- Thread 1 lookup on IP 0x0A000001 after a cfg write of that IP at addr 3, action 4'b0101 -> resp_match=1, resp_action=4'b0101 on resp_valid[1].
- cfg_req while 2 lookups are in flight -> both responses delivered; acc_setup_ft issued the cycle after inflight reaches 0; no gnt for 16 cycles after cfg_ack.
- req_eop=1 for thread 3 -> acc_end_of_pkt high exactly 1 cycle after that acc_start; req_eop=0 -> stays low.
- cnt_rd_req at addr 5 during SETTLE -> cnt_rd_valid 1 cycle later with acc_count; reset asserted mid-DRAIN -> all outputs 0, state RUN.
